// File: rtl/keccak_rho_pi_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : keccak_pkg
//  Description : Shared constants for the lane-serial Keccak rho+pi stage:
//                rho rotation offsets, pi destination table, FSM encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package keccak_pkg;

    localparam int LANES  = 25;
    localparam int LANE_W = 64;
    localparam int CNT_W  = 5;
    localparam int ROT_W  = 9;

    localparam logic [CNT_W-1:0] CNT_LAST = 5'd24;

    // Rho rotation offset for source lane i = x + 5y
    localparam int RHO_OFF [0:24] = '{
         0,  1, 62, 28, 27,
        36, 44,  6, 55, 20,
         3, 10, 43, 25, 39,
        41, 45, 15, 21,  8,
        18,  2, 61, 56, 14
    };

    // Pi destination of source lane i: y + 5*((2x+3y) mod 5)
    localparam int PI_DST [0:24] = '{
         0, 10, 20,  5, 15,
        16,  1, 11, 21,  6,
         7, 17,  2, 12, 22,
        23,  8, 18,  3, 13,
        14, 24,  9, 19,  4
    };

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage
`default_nettype wire

// File: rtl/keccak_rho_pi_seq_rol64.sv
`default_nettype none
// ============================================================================
//  Module      : rol64
//  Description : Combinational left-rotate of a BW_A-bit lane by i_n bits.
//                Log-depth barrel; amounts wrap modulo BW_A.
//  Revision    : 1.0 - initial release
// ============================================================================
module rol64 #(
    parameter int BW_A = 64,
    parameter int BW_N = 9
) (
    input  logic [BW_A-1:0] i_a,
    input  logic [BW_N-1:0] i_n,
    output logic [BW_A-1:0] o_y
);

    // Constant-amount rotate; a zero amount returns the operand unchanged
    function automatic logic [BW_A-1:0] rotl_c(input logic [BW_A-1:0] a, input int sh);
        return (a << sh) | (a >> ((BW_A - sh) % BW_A));
    endfunction

    logic [BW_A-1:0] stage [0:BW_N];

    assign stage[0] = i_a;

    // Stage k rotates by 2^k mod BW_A, so amount bits above log2(BW_A) are no-ops
    for (genvar k = 0; k < BW_N; k++) begin : g_stage
        localparam int SH = (1 << k) % BW_A;
        assign stage[k+1] = i_n[k] ? rotl_c(stage[k], SH) : stage[k];
    end

    assign o_y = stage[BW_N];

endmodule
`default_nettype wire

// File: rtl/keccak_rho_pi_seq.sv
`default_nettype none
// ============================================================================
//  Module      : keccak_rho_pi_seq
//  Description : Lane-serial Keccak rho+pi. Captures a 1600-bit state, then
//                rotates one lane per cycle through a shared rotator and
//                writes it to its pi-permuted position. 25-cycle latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module keccak_rho_pi_seq
    import keccak_pkg::*;
#(
    parameter int BW_A = 64,
    parameter int BW_N = 9,
    parameter int BW_S = 1600
) (
    input  logic            i_clk,
    input  logic            i_rstn,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [BW_S-1:0] i_state,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [BW_S-1:0] o_state,
    output logic            o_busy
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [BW_S-1:0]  in_q,    in_d;
    logic [BW_S-1:0]  out_q,   out_d;

    logic [BW_A-1:0]  lane_sel;
    logic [BW_A-1:0]  lane_rot;
    logic [BW_N-1:0]  rot_amt;

    // State register: FSM, lane counter, captured input and assembled output
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            in_q    <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            in_q    <= in_d;
            out_q   <= out_d;
        end
    end

    // Next-state logic; the counter parks at the last lane instead of wrapping
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (i_valid) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            ST_DONE: begin
                if (i_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Lane mux: select source lane cnt and its rho offset for the rotator
    always_comb begin
        lane_sel = '0;
        rot_amt  = '0;
        for (int i = 0; i < LANES; i++) begin
            if (cnt_q == CNT_W'(i)) begin
                lane_sel = in_q[i*BW_A +: BW_A];
                rot_amt  = BW_N'(RHO_OFF[i]);
            end
        end
    end

    rol64 #(
        .BW_A (BW_A),
        .BW_N (BW_N)
    ) u_rol64 (
        .i_a  (lane_sel),
        .i_n  (rot_amt),
        .o_y  (lane_rot)
    );

    // Datapath: capture on accept, write rotated lane to its pi destination
    always_comb begin
        in_d  = in_q;
        out_d = out_q;
        if (state_q == ST_IDLE && i_valid) begin
            in_d = i_state;
        end
        if (state_q == ST_RUN) begin
            for (int i = 0; i < LANES; i++) begin
                if (cnt_q == CNT_W'(i)) begin
                    out_d[PI_DST[i]*BW_A +: BW_A] = lane_rot;
                end
            end
        end
    end

    // Output decode from the current FSM state
    always_comb begin
        o_ready = (state_q == ST_IDLE);
        o_busy  = (state_q == ST_RUN);
        o_valid = (state_q == ST_DONE);
        o_state = out_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_keccak_rho_pi_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_keccak_rho_pi_seq
//  Description : Self-checking bench for keccak_rho_pi_seq with a scoreboard
//                queue filled at accept and drained by an output monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_keccak_rho_pi_seq;

    localparam int BW_A = 64;
    localparam int BW_N = 9;
    localparam int BW_S = 1600;

    logic            i_clk;
    logic            i_rstn;
    logic            i_valid;
    logic            o_ready;
    logic [BW_S-1:0] i_state;
    logic            o_valid;
    logic            i_ready;
    logic [BW_S-1:0] o_state;
    logic            o_busy;

    int checks = 0;
    int errors = 0;
    int n_out  = 0;
    int n_sent = 0;
    int n_disc = 0;

    logic [BW_S-1:0] exp_q [$];
    bit              rdy_rand  = 1'b0;
    logic            rdy_fixed = 1'b1;

    int rho_tb [25] = '{0, 1, 62, 28, 27, 36, 44, 6, 55, 20, 3, 10, 43,
                        25, 39, 41, 45, 15, 21, 8, 18, 2, 61, 56, 14};

    keccak_rho_pi_seq #(
        .BW_A (BW_A),
        .BW_N (BW_N),
        .BW_S (BW_S)
    ) dut (
        .i_clk   (i_clk),
        .i_rstn  (i_rstn),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_state (i_state),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_state (o_state),
        .o_busy  (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Reference rho+pi computed from the lane coordinates
    function automatic logic [BW_S-1:0] ref_rho_pi(input logic [BW_S-1:0] s);
        logic [BW_S-1:0] res;
        logic [63:0]     ln;
        int              i, d, r;
        res = '0;
        for (int x = 0; x < 5; x++) begin
            for (int y = 0; y < 5; y++) begin
                i  = x + 5*y;
                d  = y + 5*((2*x + 3*y) % 5);
                ln = s[i*64 +: 64];
                r  = rho_tb[i];
                res[d*64 +: 64] = (r == 0) ? ln : ((ln << r) | (ln >> (64 - r)));
            end
        end
        return res;
    endfunction

    function automatic logic [BW_S-1:0] rand_state();
        logic [BW_S-1:0] s;
        for (int k = 0; k < BW_S/32; k++) s[k*32 +: 32] = $urandom;
        return s;
    endfunction

    task automatic check_state(input string name, input logic [BW_S-1:0] got,
                               input logic [BW_S-1:0] exp);
        int bad;
        checks++;
        if (got !== exp) begin
            errors++;
            bad = 0;
            for (int k = 24; k >= 0; k--)
                if (got[k*64 +: 64] !== exp[k*64 +: 64]) bad = k;
            $display("FAIL %s lane %0d got %h expected %h", name, bad,
                     got[bad*64 +: 64], exp[bad*64 +: 64]);
        end
    endtask

    task automatic check_val(input string name, input logic [63:0] got,
                             input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Offer a state until accepted, then record the expected result
    task automatic send(input logic [BW_S-1:0] s, input logic [BW_S-1:0] e);
        int n;
        n       = 0;
        i_state = s;
        i_valid = 1'b1;
        while (!o_ready && n < 200) begin
            tick();
            n++;
        end
        if (!o_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout got o_ready=%0b expected 1", o_ready);
            i_valid = 1'b0;
            return;
        end
        exp_q.push_back(e);
        n_sent++;
        tick();
        i_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !o_ready) && n < 300) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0 || !o_ready) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout got pending=%0d expected 0", exp_q.size());
        end
    endtask

    // Downstream ready: fixed level or random stalls
    initial begin
        i_ready = 1'b0;
        forever begin
            @(posedge i_clk);
            #1;
            i_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fixed;
        end
    end

    // Monitor: compare each completed output handshake against the scoreboard
    initial begin
        logic [BW_S-1:0] e;
        forever begin
            @(negedge i_clk);
            if (i_rstn && o_valid && i_ready) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected got output with empty queue expected none");
                end else begin
                    e = exp_q.pop_front();
                    check_state("sb_state", o_state, e);
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [BW_S-1:0] s, e, snap;
        int              n, out0;

        i_rstn  = 1'b0;
        i_valid = 1'b0;
        i_state = '0;
        repeat (3) tick();
        check_val("rst_ready", 64'(o_ready), 64'd1);
        check_val("rst_valid", 64'(o_valid), 64'd0);
        check_val("rst_busy",  64'(o_busy),  64'd0);
        check_state("rst_state", o_state, '0);
        i_rstn = 1'b1;
        tick();

        // Single-lane tracing with hand-computed results
        rdy_fixed = 1'b1;
        s = '0; s[1*64 +: 64]  = 64'h1;                e = '0; e[10*64 +: 64] = 64'h2;
        send(s, e); wait_drain();
        s = '0; s[24*64 +: 64] = 64'h8000000000000000; e = '0; e[4*64 +: 64]  = 64'h0000000000002000;
        send(s, e); wait_drain();
        s = '0; s[0*64 +: 64]  = 64'hDEADBEEFCAFEF00D; e = '0; e[0*64 +: 64]  = 64'hDEADBEEFCAFEF00D;
        send(s, e); wait_drain();

        // Latency and backpressure
        rdy_fixed = 1'b0;
        tick();
        s = rand_state();
        send(s, ref_rho_pi(s));
        n = 0;
        while (!o_valid && n < 40) begin
            tick();
            n++;
        end
        check_val("latency", 64'(n), 64'd25);
        snap = o_state;
        for (int k = 0; k < 10; k++) begin
            tick();
            check_val("hold_valid", 64'(o_valid), 64'd1);
            check_state("hold_state", o_state, snap);
        end
        rdy_fixed = 1'b1;
        n = 0;
        while (o_valid && n < 5) begin
            tick();
            n++;
        end
        check_val("ready_after_hs", 64'(o_ready), 64'd1);
        wait_drain();

        // Input change after accept and ignored valid during RUN
        s = rand_state();
        out0 = n_out;
        send(s, ref_rho_pi(s));
        for (int k = 0; k < 10; k++) begin
            i_state = rand_state();
            i_valid = (k >= 2);
            tick();
        end
        i_valid = 1'b0;
        wait_drain();
        repeat (5) tick();
        check_val("one_txn", 64'(n_out - out0), 64'd1);

        // Reset mid-RUN discards the in-flight state
        s = rand_state();
        send(s, ref_rho_pi(s));
        repeat (9) tick();
        i_rstn = 1'b0;
        tick();
        exp_q.delete();
        n_disc++;
        i_rstn = 1'b1;
        check_val("midrst_ready", 64'(o_ready), 64'd1);
        check_val("midrst_valid", 64'(o_valid), 64'd0);
        check_val("midrst_busy",  64'(o_busy),  64'd0);
        check_state("midrst_state", o_state, '0);
        s = rand_state();
        send(s, ref_rho_pi(s));
        wait_drain();

        // Random regression with upstream gaps and downstream stalls
        rdy_rand = 1'b1;
        for (int t = 0; t < 200; t++) begin
            s = rand_state();
            send(s, ref_rho_pi(s));
            repeat ($urandom_range(0, 3)) tick();
        end
        wait_drain();
        rdy_rand = 1'b0;
        repeat (5) tick();

        check_val("queue_empty", 64'(exp_q.size()), 64'd0);
        check_val("out_count",   64'(n_out), 64'(n_sent - n_disc));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
